// File: rtl/btb_bht.sv
// -----------------------------------------------------------------------------
// btb_bht -- direct-mapped branch target buffer with a per-entry saturating
// counter branch history table, used by the IF stage of the RV32 pipeline.
//
// Parameters:
//   INDEX_LEN  log2 of the entry count; PC[INDEX_LEN+1:2] selects the entry.
//   CNT_BITS   width of each saturating counter (1..4).
//   TAG_LEN    derived: tag = PC[31:INDEX_LEN+2].
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   rd_pc               lookup PC from IF (combinational, zero latency)
//   rd_hit              indexed entry valid and tag matches
//   rd_pred_taken       rd_hit and counter MSB set
//   rd_target           stored target when rd_hit, otherwise 0
//   upd_en              one resolved-branch update per cycle from EX
//   upd_pc/upd_taken    resolved branch PC and outcome
//   upd_target          resolved target (used when upd_taken=1)
//   flush               synchronous invalidate-all, wins over upd_en
//
// Optional build macro BTB_BHT_PERF_CNT_EN adds:
//   perf_upd_cnt        number of accepted updates (wraps mod 2^32)
//   perf_mispred_cnt    accepted updates whose pre-update prediction was wrong
// -----------------------------------------------------------------------------
module btb_bht #(
   parameter int INDEX_LEN = 6,
   parameter int CNT_BITS  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rd_pc,
   output logic        rd_hit,
   output logic        rd_pred_taken,
   output logic [31:0] rd_target,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        flush
`ifdef BTB_BHT_PERF_CNT_EN
   ,
   output logic [31:0] perf_upd_cnt,
   output logic [31:0] perf_mispred_cnt
`endif
);

   localparam int TAG_LEN = 32 - INDEX_LEN - 2;
   localparam int ENTRIES = 1 << INDEX_LEN;

   // Counter encodings: WT is the weakest taken state, WNT the weakest
   // not-taken state directly below it.
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_ONE << (CNT_BITS - 1);
   localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_ONE;

   // ---------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------

   // Saturating increment: holds at the all-ones maximum.
   function automatic logic [CNT_BITS-1:0] cnt_inc(input logic [CNT_BITS-1:0] c);
      logic [CNT_BITS-1:0] r;
      if (c == CNT_MAX) begin
         r = c;
      end else begin
         r = c + CNT_ONE;
      end
      return r;
   endfunction

   // Saturating decrement: holds at zero.
   function automatic logic [CNT_BITS-1:0] cnt_dec(input logic [CNT_BITS-1:0] c);
      logic [CNT_BITS-1:0] r;
      if (c == {CNT_BITS{1'b0}}) begin
         r = c;
      end else begin
         r = c - CNT_ONE;
      end
      return r;
   endfunction

   // Wrong prediction: direction disagrees, or a taken hit pointed elsewhere.
   function automatic logic is_mispred(input logic hit,
                                       input logic msb,
                                       input logic tgt_match,
                                       input logic taken);
      return ((hit & msb) != taken) | (taken & hit & ~tgt_match);
   endfunction

   // ---------------------------------------------------------------------
   // Table state
   // ---------------------------------------------------------------------
   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_LEN-1:0]  tag_q    [ENTRIES];
   logic [TAG_LEN-1:0]  tag_d    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [31:0]         target_d [ENTRIES];
   logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
   logic [CNT_BITS-1:0] cnt_d    [ENTRIES];

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic [INDEX_LEN-1:0] rd_idx_s;
   logic [TAG_LEN-1:0]   rd_tag_s;
   logic [INDEX_LEN-1:0] upd_idx_s;
   logic [TAG_LEN-1:0]   upd_tag_s;
   logic                 unused_pc_lsb_s;

   assign rd_idx_s  = rd_pc[INDEX_LEN+1:2];
   assign rd_tag_s  = rd_pc[31:INDEX_LEN+2];
   assign upd_idx_s = upd_pc[INDEX_LEN+1:2];
   assign upd_tag_s = upd_pc[31:INDEX_LEN+2];

   // Byte offset within the instruction word never affects the table.
   assign unused_pc_lsb_s = ^{rd_pc[1:0], upd_pc[1:0]};

   // ---------------------------------------------------------------------
   // Lookup port: reads current (pre-edge) state, no bypass of updates.
   // ---------------------------------------------------------------------

   // Combinational hit / direction / target for the IF stage.
   always_comb begin
      rd_hit        = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s);
      rd_pred_taken = rd_hit && cnt_q[rd_idx_s][CNT_BITS-1];
      if (rd_hit) begin
         rd_target = target_q[rd_idx_s];
      end else begin
         rd_target = 32'h0000_0000;
      end
   end

   // ---------------------------------------------------------------------
   // Update port
   // ---------------------------------------------------------------------
   logic                upd_hit_s;
   logic [CNT_BITS-1:0] upd_cnt_cur_s;
   logic [31:0]         upd_tgt_cur_s;
   logic                upd_accept_s;

   // Pre-update view of the entry addressed by the resolved branch.
   always_comb begin
      upd_hit_s     = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
      upd_cnt_cur_s = cnt_q[upd_idx_s];
      upd_tgt_cur_s = target_q[upd_idx_s];
      upd_accept_s  = upd_en && !flush;
   end

   // Next-state for the table; flush drops any same-cycle update.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      if (flush) begin
         // Only valid bits clear; stale counters/targets stay but are unreachable.
         valid_d = {ENTRIES{1'b0}};
      end else if (upd_en) begin
         case ({upd_hit_s, upd_taken})
            2'b11: begin
               cnt_d[upd_idx_s]    = cnt_inc(upd_cnt_cur_s);
               target_d[upd_idx_s] = upd_target;
            end
            2'b10: begin
               cnt_d[upd_idx_s] = cnt_dec(upd_cnt_cur_s);
            end
            2'b01: begin
               // Direct-mapped allocate: evicts whatever tag lived here.
               valid_d[upd_idx_s]  = 1'b1;
               tag_d[upd_idx_s]    = upd_tag_s;
               target_d[upd_idx_s] = upd_target;
               cnt_d[upd_idx_s]    = CNT_WT;
            end
            2'b00: begin
               // Not-taken branch that is not in the table: nothing to learn.
               valid_d = valid_q;
            end
            default: begin
               valid_d = valid_q;
            end
         endcase
      end else begin
         valid_d = valid_q;
      end
   end

   // Table registers; reset returns every entry to invalid / WNT / target 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= {ENTRIES{1'b0}};
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= {TAG_LEN{1'b0}};
            target_q[i] <= 32'h0000_0000;
            cnt_q[i]    <= CNT_WNT;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef BTB_BHT_PERF_CNT_EN
   // ---------------------------------------------------------------------
   // Performance counters (cleared only by rst, not by flush)
   // ---------------------------------------------------------------------
   logic [31:0] perf_upd_q, perf_upd_d;
   logic [31:0] perf_mispred_q, perf_mispred_d;
   logic        upd_mispred_s;

   // Count accepted updates and those the pre-edge table mispredicted.
   always_comb begin
      upd_mispred_s  = is_mispred(upd_hit_s, upd_cnt_cur_s[CNT_BITS-1],
                                  (upd_tgt_cur_s == upd_target), upd_taken);
      perf_upd_d     = perf_upd_q;
      perf_mispred_d = perf_mispred_q;
      if (upd_accept_s) begin
         perf_upd_d = perf_upd_q + 32'd1;
         if (upd_mispred_s) begin
            perf_mispred_d = perf_mispred_q + 32'd1;
         end else begin
            perf_mispred_d = perf_mispred_q;
         end
      end else begin
         perf_upd_d = perf_upd_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_upd_q     <= 32'h0000_0000;
         perf_mispred_q <= 32'h0000_0000;
      end else begin
         perf_upd_q     <= perf_upd_d;
         perf_mispred_q <= perf_mispred_d;
      end
   end

   assign perf_upd_cnt     = perf_upd_q;
   assign perf_mispred_cnt = perf_mispred_q;
`else
   logic unused_perf_s;

   // Without the counters the mispredict helper and accept term are idle.
   assign unused_perf_s = upd_accept_s ^ (upd_tgt_cur_s == upd_target) ^
                          is_mispred(1'b0, 1'b0, 1'b1, 1'b0);
`endif

endmodule
